pll_lock_rst_gen: RTL and testbench



---
 rtl/pll_rst_pkg.sv | 18 +
 rtl/cdc_sync_bit.sv | 21 ++
 rtl/pll_lock_rst_gen.sv | 90 +++++++++
 tb/tb_pll_lock_rst_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and sizing helper for the PLL reset sequencer
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop synchroniser for one asynchronous bit, clears to 0
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_gen.sv
// pll_lock_rst_gen: releases a domain reset only after PLL lock has been stable, re-asserts on lock loss
module pll_lock_rst_gen
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  rst_out_n,
    output logic                  stdy_rst,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            state_o
);

    localparam int MAX_C = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W = (clog2(MAX_C) < 1) ? 1 : clog2(MAX_C);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic                  w_lock_s;
    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [LOSS_CNT_W-1:0] r_loss, w_loss_nxt;
    logic                  r_rst_out_n, r_stdy_rst;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_lock_s)
    );

    // next-state, cycle counter and saturating lock-loss count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_nxt  = r_loss;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABILIZE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_STABILIZE: begin
                if (!w_lock_s)                w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == STABLE_LAST) w_state_nxt = ST_RUN;
                else                           w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_loss_nxt  = (&r_loss) ? r_loss : r_loss + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == HOLD_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    // state register; outputs are flops loaded from the next state so they never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_loss      <= '0;
            r_rst_out_n <= 1'b0;
            r_stdy_rst  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_loss      <= w_loss_nxt;
            r_rst_out_n <= (w_state_nxt == ST_RUN);
            r_stdy_rst  <= (w_state_nxt == ST_HOLD);
        end
    end

    assign rst_out_n     = r_rst_out_n;
    assign stdy_rst      = r_stdy_rst;
    assign lock_loss_cnt = r_loss;
    assign state_o       = r_state;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// tb_pll_lock_rst_gen: vector table, corner sequences and random lock traffic against a timestamp model
module tb_pll_lock_rst_gen;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       ron_a, stdy_a, ron_b, stdy_b;
    logic [7:0] loss_a;
    logic [1:0] loss_b, st_a, st_b;

    int checks = 0;
    int errors = 0;
    int ph = 0, t0 = 0, cyc = 0, loss = 0;
    bit hist[$];

    typedef struct {
        bit         rn;
        bit         lk;
        logic [1:0] st;
        bit         ron;
        bit         stdy;
        logic [7:0] loss;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    pll_lock_rst_gen #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .LOSS_CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .rst_out_n(ron_a), .stdy_rst(stdy_a), .lock_loss_cnt(loss_a), .state_o(st_a)
    );

    pll_lock_rst_gen #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .LOSS_CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .rst_out_n(ron_b), .stdy_rst(stdy_b), .lock_loss_cnt(loss_b), .state_o(st_b)
    );

    function automatic void add(bit rn, bit lk, logic [1:0] st, bit ron, bit stdy, logic [7:0] ls);
        vt.push_back('{rn, lk, st, ron, stdy, ls});
    endfunction

    // Phase model: lock seen SYNC edges late; stabilise ends STABLE edges after entry, hold HOLD edges after entry.
    task automatic model_edge();
        bit ls;
        if (!rst) begin
            hist.delete();
            ph = 0; t0 = 0; cyc = 0; loss = 0;
        end else begin
            cyc++;
            ls = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : 1'b0;
            hist.push_back(pll_locked);
            if (hist.size() > 8) void'(hist.pop_front());
            case (ph)
                0: if (ls) begin ph = 1; t0 = cyc; end
                1: if (!ls) ph = 0; else if (cyc - t0 == STABLE) ph = 2;
                2: if (!ls) begin ph = 3; t0 = cyc; loss++; end
                default: if (cyc - t0 == HOLD) ph = 0;
            endcase
        end
    endtask

    task automatic check(string nm, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        int l8, l2;
        l8 = (loss > 255) ? 255 : loss;
        l2 = (loss > 3) ? 3 : loss;
        check("model_w8", {st_a, ron_a, stdy_a, loss_a}, {2'(ph), ph == 2, ph == 3, 8'(l8)});
        check("model_w2", {st_b, ron_b, stdy_b, 6'd0, loss_b}, {2'(ph), ph == 2, ph == 3, 6'd0, 2'(l2)});
    endtask

    task automatic tick(bit rn, bit lk);
        rst = rn;
        pll_locked = lk;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        int hc;
        bit tg, lk;
        int sat_exp[5] = '{1, 2, 3, 3, 3};

        repeat (5) add(0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0);
        repeat (4) add(1, 1, 1, 0, 0, 0);
        add(1, 1, 2, 1, 0, 0); add(1, 1, 2, 1, 0, 0);
        add(1, 0, 2, 1, 0, 0); add(1, 0, 2, 1, 0, 0); add(1, 0, 3, 0, 1, 1);
        add(1, 1, 3, 0, 1, 1); add(1, 1, 3, 0, 1, 1); add(1, 1, 0, 0, 0, 1);
        repeat (4) add(1, 1, 1, 0, 0, 1);
        add(1, 1, 2, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0); add(1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0);
        repeat (4) add(1, 1, 1, 0, 0, 0);
        add(1, 1, 2, 1, 0, 0); add(1, 1, 2, 1, 0, 0);

        @(negedge clk);
        check("reset_state", {st_a, ron_a, stdy_a, loss_a}, 12'd0);
        foreach (vt[i]) begin
            tick(vt[i].rn, vt[i].lk);
            check($sformatf("vec%0d", i), {st_a, ron_a, stdy_a, loss_a},
                  {vt[i].st, vt[i].ron, vt[i].stdy, vt[i].loss});
        end

        tick(0, 1); tick(0, 1);
        for (int k = 0; k < 20 && !ron_a; k++) tick(1, 1);
        check("hold_reach_run", 12'(ron_a), 12'd1);
        for (int k = 0; k < 10 && st_a != 2'd3; k++) tick(1, 0);
        check("hold_entered", 12'(st_a), 12'd3);
        hc = 1;
        tg = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1, tg);
            tg = ~tg;
            if (st_a == 2'd3) hc++;
            else break;
        end
        check("hold_length", 12'(hc), 12'(HOLD));
        repeat (8) begin
            tick(1, tg);
            tg = ~tg;
        end
        check("hold_single_loss", 12'(loss_a), 12'd1);

        tick(0, 0); tick(0, 0);
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 20 && !ron_a; k++) tick(1, 1);
            check("sat_run", 12'(ron_a), 12'd1);
            for (int k = 0; k < 10 && st_a != 2'd3; k++) tick(1, 0);
            check("sat_hold", 12'(st_a), 12'd3);
            check($sformatf("sat_cnt%0d", n), 12'(loss_b), 12'(sat_exp[n]));
            check($sformatf("wide_cnt%0d", n), 12'(loss_a), 12'(n + 1));
        end
        for (int k = 0; k < 20 && !ron_a; k++) tick(1, 1);
        check("async_pre_run", 12'(ron_a), 12'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_a", {st_a, ron_a, stdy_a, loss_a}, 12'd0);
        check("async_rst_b", {st_b, ron_b, stdy_b, 6'd0, loss_b}, 12'd0);
        tick(0, 0);

        for (int r = 0; r < 300; r++) begin
            lk = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 14)) tick($urandom_range(0, 499) != 0, lk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
